lif_recall_engine: RTL
======================

// Module: lif_recall_engine
// PURPOSE
//  Time-multiplexed recall engine for one neuron per evaluation: I&F, ReLU and leaky I&F (LIF).
//  Streams (weight, spike) beats from the synapse/in-spike memories and applies leak, saturating
//  accumulation and bias. Runs a signed threshold compare with a refractory counter, then hands
//  the updated status back to the status memory over a valid/ready port.
//  Sits between the neuron controller (start/busy) and the status memory/router.
// PARAMETERS
//  DATA_BIT_WIDTH_INT   8  integer bits of signed fixed-point data (incl. sign)
//  DATA_BIT_WIDTH_FRAC  8  fraction bits; DSIZE = INT+FRAC
//  NUM_AXONS          256  max weight beats per evaluation
//  AXON_CNT_BIT_WIDTH   8  beat counter width, >= clog2(NUM_AXONS)
//  REFRAC_BIT_WIDTH     4  refractory counter width
//  LEAK_SHIFT_WIDTH     3  width of leak shift amount
// PORTS
//  clk_i          in   1      clock
//  rst_n_i        in   1      reset, asynchronous, active-low
//  start_i        in   1      start evaluation (sampled only in IDLE)
//  busy_o         out  1      high from cycle after start until WB handshake
//  nurnType_i     in   2      00 I&F, 01 ReLU, 10 LIF, 11 treated as I&F
//  leakShift_i    in   LEAK_SHIFT_WIDTH  LIF leak = pot >>> leakShift (arith)
//  rstPot_i       in   DSIZE  reset potential after spike
//  refracPer_i    in   REFRAC_BIT_WIDTH  refractory period loaded on spike
//  membPot_i      in   DSIZE  stored membrane potential (latched at start)
//  th_i           in   DSIZE  signed threshold (latched at start)
//  bias_i         in   DSIZE  signed bias (latched at start)
//  refracCnt_i    in   REFRAC_BIT_WIDTH  stored refractory count (latched at start)
//  wt_valid_i     in   1      weight beat valid
//  wt_ready_o     out  1      weight beat accepted when valid&ready
//  wt_data_i      in   DSIZE  signed weight
//  wt_spike_i     in   1      input spike for this axon
//  wt_last_i      in   1      final beat of evaluation
//  wb_valid_o     out  1      writeback valid, held until wb_ready_i
//  wb_ready_i     in   1      status memory accepts writeback
//  wb_membPot_o   out  DSIZE  new membrane potential
//  wb_refracCnt_o out  REFRAC_BIT_WIDTH  new refractory count
//  outSpike_o     out  1      single-cycle spike pulse to router
//  sat_o          out  1      single-cycle pulse: any add/leak clipped
// BEHAVIOUR
//  - Reset: state IDLE; busy_o, wt_ready_o, wb_valid_o, outSpike_o, sat_o = 0; wb_* data = 0.
//    Reset mid-operation aborts with no writeback.
//  - FSM: IDLE -> LOAD -> ACC -> BIAS -> CMP -> WB -> IDLE. start_i while busy is ignored.
//  - LOAD (1 cyc): acc <= membPot_i, or for LIF acc <= membPot_i - (membPot_i >>> leakShift_i).
//    refr = (refracCnt_i != 0).
//  - ACC: wt_ready_o = 1. Each accepted beat with wt_spike_i=1 and !refr: acc <= sat(acc + wt_data_i).
//    Beat counter increments. Exit on accepted beat with wt_last_i, or on the NUM_AXONS-th beat.
//    Minimum one beat. wt_ready_o = 0 in every other state.
//  - BIAS (1 cyc): if !refr, acc <= sat(acc + bias).
//  - CMP (1 cyc): spike = !refr & ($signed(acc) >= $signed(th)); ReLU never spikes.
//  - Writeback values:
//      I&F/LIF spike: membPot = rstPot_i, refracCnt = refracPer_i.
//      No spike: membPot = acc, refracCnt = refr ? refracCnt-1 : 0.
//      Refractory neuron: membPot = latched membPot_i (no leak).
//      ReLU: membPot = max(acc, 0), refracCnt = 0.
//  - WB: wb_valid_o high, data stable until wb_ready_i. outSpike_o pulses only in the first WB cycle.
//    IDLE is entered on handshake; busy_o falls the next cycle.
//  - Latency: start at cycle 0, N beats back-to-back, wb_ready_i=1 -> wb_valid_o in cycle N+4.
//  - sat: clip to 0x7F..F / 0x80..0; sat_o pulses in the cycle the clipped value is registered.
// STRUCTURE
//  - Shared package neuron_pkg: FSM state enum, NURN_IF/RELU/LIF codes, DSIZE-generic SAT_MAX/SAT_MIN.
//  - One sub-module: existing Adder_2sComp (clipped_sum_o, overflow_o/underflow_o -> sat_o),
//    shared by the ACC/BIAS adds.
// TESTING (Q8.8, DSIZE=16)
//  1. I&F: membPot 0x0100, th 0x0400, bias 0, beats (0x0180,1),(0x0180,1),(0x7000,0,last)
//     -> acc 0x0400; spike; wb_membPot=rstPot 0x0000, refrac=refracPer 3; outSpike once at cycle 7.
//  2. Saturation: membPot 0x7F00 + (0x0200,1) -> 0x7FFF with sat_o pulse.
//     membPot 0x8100 + (0xFE00,1) -> 0x8000 with sat_o pulse.
//  3. LIF: membPot 0x0800, leakShift 2, one beat (0x1000,0), bias 0x0010, th 0x1000
//     -> wb_membPot 0x0610, no spike.
//  4. Refractory: refracCnt_i 2, 4 beats (0x4000,1) -> all accepted, no spike,
//     wb_membPot = membPot_i, wb_refracCnt 1.
//  5. Backpressure: wt_valid_i toggling, wb_ready_i low 5 cycles -> wb_* held stable,
//     outSpike_o single pulse, start_i during busy ignored.
//  6. ReLU acc -0x0200 -> wb_membPot 0x0000; rst_n_i low mid-ACC -> all outputs 0, IDLE, no writeback.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared neuron definitions: recall FSM states, neuron type codes and
// width-generic saturation limits for signed fixed-point data.
package neuron_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACC,
        ST_BIAS,
        ST_CMP,
        ST_WB
    } state_t;

    localparam logic [1:0] NURN_IF   = 2'b00;
    localparam logic [1:0] NURN_RELU = 2'b01;
    localparam logic [1:0] NURN_LIF  = 2'b10;

    // Limits are returned wide; callers cast down to their own data width.
    function automatic logic [63:0] sat_max(input int unsigned dsize);
        return (64'd1 << (dsize - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned dsize);
        return 64'd1 << (dsize - 1);
    endfunction

endpackage

// File: rtl/Adder_2sComp.sv
// Two's-complement adder that clips to the most positive / most negative
// representable value and flags which way it clipped.
module Adder_2sComp
    import neuron_pkg::*;
#(
    parameter int DSIZE = 16
) (
    input  logic [DSIZE-1:0] a_i,
    input  logic [DSIZE-1:0] b_i,
    output logic [DSIZE-1:0] clipped_sum_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam logic [DSIZE-1:0] SAT_MAX = DSIZE'(sat_max(DSIZE));
    localparam logic [DSIZE-1:0] SAT_MIN = DSIZE'(sat_min(DSIZE));

    logic [DSIZE-1:0] w_raw_sum;

    assign w_raw_sum = a_i + b_i;

    // Overflow is only possible when both operands share a sign the result lacks.
    assign overflow_o  = !a_i[DSIZE-1] && !b_i[DSIZE-1] &&  w_raw_sum[DSIZE-1];
    assign underflow_o =  a_i[DSIZE-1] &&  b_i[DSIZE-1] && !w_raw_sum[DSIZE-1];

    always_comb begin
        if (overflow_o) begin
            clipped_sum_o = SAT_MAX;
        end else if (underflow_o) begin
            clipped_sum_o = SAT_MIN;
        end else begin
            clipped_sum_o = w_raw_sum;
        end
    end

endmodule

// File: rtl/lif_recall_engine.sv
// Time-multiplexed recall engine for one neuron (I&F, ReLU, LIF): leak, streamed
// saturating accumulation, bias, threshold/refractory update and status writeback.
module lif_recall_engine
    import neuron_pkg::*;
#(
    parameter int DATA_BIT_WIDTH_INT  = 8,
    parameter int DATA_BIT_WIDTH_FRAC = 8,
    parameter int NUM_AXONS           = 256,
    parameter int AXON_CNT_BIT_WIDTH  = 8,
    parameter int REFRAC_BIT_WIDTH    = 4,
    parameter int LEAK_SHIFT_WIDTH    = 3,
    localparam int DSIZE = DATA_BIT_WIDTH_INT + DATA_BIT_WIDTH_FRAC
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        start_i,
    output logic                        busy_o,
    input  logic [1:0]                  nurnType_i,
    input  logic [LEAK_SHIFT_WIDTH-1:0] leakShift_i,
    input  logic [DSIZE-1:0]            rstPot_i,
    input  logic [REFRAC_BIT_WIDTH-1:0] refracPer_i,
    input  logic [DSIZE-1:0]            membPot_i,
    input  logic [DSIZE-1:0]            th_i,
    input  logic [DSIZE-1:0]            bias_i,
    input  logic [REFRAC_BIT_WIDTH-1:0] refracCnt_i,
    input  logic                        wt_valid_i,
    output logic                        wt_ready_o,
    input  logic [DSIZE-1:0]            wt_data_i,
    input  logic                        wt_spike_i,
    input  logic                        wt_last_i,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i,
    output logic [DSIZE-1:0]            wb_membPot_o,
    output logic [REFRAC_BIT_WIDTH-1:0] wb_refracCnt_o,
    output logic                        outSpike_o,
    output logic                        sat_o
);

    localparam logic [AXON_CNT_BIT_WIDTH-1:0] LAST_BEAT_IDX = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);

    state_t                        r_state;
    state_t                        w_next_state;

    logic [DSIZE-1:0]              r_acc;
    logic [DSIZE-1:0]              r_memb_pot;
    logic [DSIZE-1:0]              r_th;
    logic [DSIZE-1:0]              r_bias;
    logic [REFRAC_BIT_WIDTH-1:0]   r_refr_cnt;
    logic [1:0]                    r_nurn;
    logic [LEAK_SHIFT_WIDTH-1:0]   r_leak_shift;
    logic                          r_refr;
    logic [AXON_CNT_BIT_WIDTH-1:0] r_beat_cnt;
    logic [DSIZE-1:0]              r_wb_memb;
    logic [REFRAC_BIT_WIDTH-1:0]   r_wb_refr;
    logic                          r_out_spike;
    logic                          r_sat;

    logic [DSIZE-1:0]              w_add_b;
    logic [DSIZE-1:0]              w_sum;
    logic                          w_ovf;
    logic                          w_unf;
    logic [DSIZE-1:0]              w_leak;
    logic                          w_beat_acc;
    logic                          w_final_beat;
    logic                          w_spike;
    logic [DSIZE-1:0]              w_wb_memb;
    logic [REFRAC_BIT_WIDTH-1:0]   w_wb_refr;

    // One adder serves both the weight beats (ACC) and the bias (BIAS).
    assign w_add_b = (r_state == ST_BIAS) ? r_bias : wt_data_i;

    Adder_2sComp #(
        .DSIZE (DSIZE)
    ) u_adder (
        .a_i           (r_acc),
        .b_i           (w_add_b),
        .clipped_sum_o (w_sum),
        .overflow_o    (w_ovf),
        .underflow_o   (w_unf)
    );

    assign w_leak       = $signed(r_memb_pot) >>> r_leak_shift;
    assign w_beat_acc   = wt_valid_i && wt_ready_o;
    assign w_final_beat = w_beat_acc && (wt_last_i || (r_beat_cnt == LAST_BEAT_IDX));
    assign w_spike      = !r_refr && (r_nurn != NURN_RELU) && ($signed(r_acc) >= $signed(r_th));

    // --- FSM: state register ---
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // --- FSM: next-state logic ---
    // NOTE: assigning a default before the case keeps combinational blocks latch-free.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (start_i)      w_next_state = ST_LOAD;
            ST_LOAD:                   w_next_state = ST_ACC;
            ST_ACC:  if (w_final_beat) w_next_state = ST_BIAS;
            ST_BIAS:                   w_next_state = ST_CMP;
            ST_CMP:                    w_next_state = ST_WB;
            ST_WB:   if (wb_ready_i)   w_next_state = ST_IDLE;
            default:                   w_next_state = ST_IDLE;
        endcase
    end

    // --- FSM: outputs ---
    always_comb begin
        busy_o     = (r_state != ST_IDLE);
        wt_ready_o = (r_state == ST_ACC);
        wb_valid_o = (r_state == ST_WB);
    end

    // A refractory neuron keeps its stored potential untouched (no leak either).
    always_comb begin
        w_wb_memb = r_acc;
        w_wb_refr = '0;
        if (r_nurn == NURN_RELU) begin
            w_wb_memb = r_acc[DSIZE-1] ? '0 : r_acc;
        end else if (r_refr) begin
            w_wb_memb = r_memb_pot;
            w_wb_refr = r_refr_cnt - REFRAC_BIT_WIDTH'(1);
        end else if (w_spike) begin
            w_wb_memb = rstPot_i;
            w_wb_refr = refracPer_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_acc        <= '0;
            r_memb_pot   <= '0;
            r_th         <= '0;
            r_bias       <= '0;
            r_refr_cnt   <= '0;
            r_nurn       <= NURN_IF;
            r_leak_shift <= '0;
            r_refr       <= 1'b0;
            r_beat_cnt   <= '0;
            r_wb_memb    <= '0;
            r_wb_refr    <= '0;
            r_out_spike  <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_out_spike <= 1'b0;
            r_sat       <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_memb_pot   <= membPot_i;
                        r_th         <= th_i;
                        r_bias       <= bias_i;
                        r_refr_cnt   <= refracCnt_i;
                        r_nurn       <= nurnType_i;
                        r_leak_shift <= leakShift_i;
                        r_beat_cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    // p - (p >>> s) lies between 0 and p, so the leak can never clip.
                    r_acc  <= (r_nurn == NURN_LIF) ? (r_memb_pot - w_leak) : r_memb_pot;
                    r_refr <= (r_refr_cnt != '0);
                end
                ST_ACC: begin
                    if (w_beat_acc) begin
                        r_beat_cnt <= r_beat_cnt + AXON_CNT_BIT_WIDTH'(1);
                        if (wt_spike_i && !r_refr) begin
                            r_acc <= w_sum;
                            r_sat <= w_ovf || w_unf;
                        end
                    end
                end
                ST_BIAS: begin
                    if (!r_refr) begin
                        r_acc <= w_sum;
                        r_sat <= w_ovf || w_unf;
                    end
                end
                ST_CMP: begin
                    r_out_spike <= w_spike;
                    r_wb_memb   <= w_wb_memb;
                    r_wb_refr   <= w_wb_refr;
                end
                default: ;
            endcase
        end
    end

    assign wb_membPot_o   = r_wb_memb;
    assign wb_refracCnt_o = r_wb_refr;
    assign outSpike_o     = r_out_spike;
    assign sat_o          = r_sat;

endmodule
